fwd_operand_stage: RTL and testbench

//  Parametrised operand-forwarding stage between ID and EX of the pipelined RISC-V core.

---
 rtl/fwd_pkg.sv | 14 +
 rtl/fwd_operand_stage_if.sv | 26 ++
 rtl/fwd_src_resolve.sv | 43 ++++
 rtl/fwd_operand_stage.sv | 124 ++++++++++++
 tb/tb_fwd_operand_stage.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// Shared types and encodings for the operand-forwarding stage.
package fwd_pkg;

   typedef enum logic [0:0] {RUN, HOLD} state_e;

   // Operand source select: 0 = register file, k = forwarding level k-1.
   localparam int unsigned SEL_RF       = 0;
   localparam int unsigned SEL_LVL_BASE = 1;

   function automatic int unsigned sel_width(input int unsigned num_fwd);
      return $clog2(num_fwd + 1);
   endfunction

endpackage

// File: rtl/fwd_operand_stage_if.sv
// Upstream bundle and downstream valid/ready bus of the operand-forwarding stage.
interface fwd_operand_stage_if #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned AW      = 5,
   parameter int unsigned SEL_W   = 2
) ();
   logic                      in_valid_i;
   logic                      in_ready_o;
   logic [NUM_SRC*AW-1:0]     rs_addr_i;
   logic [NUM_SRC*XLEN-1:0]   rf_data_i;
   logic                      out_valid_o;
   logic                      out_ready_i;
   logic [NUM_SRC*XLEN-1:0]   op_data_o;
   logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o;

   modport master (
      output in_valid_i, rs_addr_i, rf_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, op_data_o, fwd_sel_o
   );

   modport slave (
      input  in_valid_i, rs_addr_i, rf_data_i, out_ready_i,
      output in_ready_o, out_valid_o, op_data_o, fwd_sel_o
   );
endinterface

// File: rtl/fwd_src_resolve.sv
// Resolves one source register against the forwarding levels, youngest level first.
module fwd_src_resolve
   import fwd_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NUM_FWD = 2,
   parameter int unsigned AW      = 5,
   parameter int unsigned SEL_W   = 2
) (
   input  logic [AW-1:0]           i_rs,
   input  logic [XLEN-1:0]         i_rf_data,
   input  logic [NUM_FWD-1:0]      i_fwd_valid,
   input  logic [NUM_FWD-1:0]      i_fwd_pend,
   input  logic [NUM_FWD*AW-1:0]   i_fwd_rd,
   input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
   output logic                    o_ready,
   output logic [XLEN-1:0]         o_value,
   output logic [SEL_W-1:0]        o_sel
);
   logic w_hit;

   always_comb begin
      w_hit   = 1'b0;
      o_ready = 1'b1;
      o_value = i_rf_data;
      o_sel   = SEL_W'(SEL_RF);
      if (i_rs == '0) begin
         o_value = '0;
      end else begin
         for (int k = 0; k < int'(NUM_FWD); k++) begin
            if (!w_hit && i_fwd_valid[k] && (i_fwd_rd[k*AW +: AW] == i_rs)) begin
               w_hit = 1'b1;
               if (i_fwd_pend[k]) begin
                  o_ready = 1'b0;
               end else begin
                  o_value = i_fwd_data[k*XLEN +: XLEN];
                  o_sel   = SEL_W'(k + int'(SEL_LVL_BASE));
               end
            end
         end
      end
   end
endmodule

// File: rtl/fwd_operand_stage.sv
// ID/EX operand-forwarding stage: resolves sources, holds on load-use, registers the bundle.
module fwd_operand_stage
   import fwd_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned NUM_FWD = 2,
   parameter int unsigned AW      = 5,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_i,
   fwd_operand_stage_if.slave      bus,
   input  logic [NUM_FWD-1:0]      fwd_valid_i,
   input  logic [NUM_FWD-1:0]      fwd_pend_i,
   input  logic [NUM_FWD*AW-1:0]   fwd_rd_i,
   input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
   output logic [CNT_W-1:0]        stall_cnt_o
);
   localparam int unsigned SEL_W = sel_width(NUM_FWD);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic                   w_res_rdy [NUM_SRC];
   logic [XLEN-1:0]        w_res_val [NUM_SRC];
   logic [SEL_W-1:0]       w_res_sel [NUM_SRC];
   logic [NUM_SRC-1:0]     w_src_rdy;
   logic [NUM_SRC*XLEN-1:0] w_op_next;
   logic [NUM_SRC*SEL_W-1:0] w_sel_next;
   logic                   w_all_ready, w_slot_free, w_load, w_latch;

   state_e                 r_state;
   logic [NUM_SRC-1:0]     r_done;
   logic [XLEN-1:0]        r_val [NUM_SRC];
   logic [SEL_W-1:0]       r_lsel [NUM_SRC];
   logic                   r_out_valid;
   logic [NUM_SRC*XLEN-1:0] r_op;
   logic [NUM_SRC*SEL_W-1:0] r_sel;
   logic [CNT_W-1:0]       r_cnt;

   for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_src
      fwd_src_resolve #(
         .XLEN    (XLEN),
         .NUM_FWD (NUM_FWD),
         .AW      (AW),
         .SEL_W   (SEL_W)
      ) u_resolve (
         .i_rs        (bus.rs_addr_i[g*AW +: AW]),
         .i_rf_data   (bus.rf_data_i[g*XLEN +: XLEN]),
         .i_fwd_valid (fwd_valid_i),
         .i_fwd_pend  (fwd_pend_i),
         .i_fwd_rd    (fwd_rd_i),
         .i_fwd_data  (fwd_data_i),
         .o_ready     (w_res_rdy[g]),
         .o_value     (w_res_val[g]),
         .o_sel       (w_res_sel[g])
      );
   end

   // Latched sources take precedence over whatever the bus shows now.
   always_comb begin
      w_src_rdy  = '0;
      w_op_next  = '0;
      w_sel_next = '0;
      for (int s = 0; s < int'(NUM_SRC); s++) begin
         w_src_rdy[s]                = r_done[s] | w_res_rdy[s];
         w_op_next[s*XLEN +: XLEN]   = r_done[s] ? r_val[s] : w_res_val[s];
         w_sel_next[s*SEL_W +: SEL_W] = r_done[s] ? r_lsel[s] : w_res_sel[s];
      end
   end

   assign w_all_ready    = &w_src_rdy;
   assign w_slot_free    = !r_out_valid | bus.out_ready_i;
   assign w_load         = bus.in_valid_i & w_all_ready & w_slot_free;
   assign w_latch        = (r_state == HOLD) | (bus.in_valid_i & !w_all_ready);
   assign bus.in_ready_o = w_slot_free & w_all_ready & !flush_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state     <= RUN;
         r_done      <= '0;
         r_out_valid <= 1'b0;
         r_op        <= '0;
         r_sel       <= '0;
         r_cnt       <= '0;
         for (int s = 0; s < int'(NUM_SRC); s++) begin
            r_val[s]  <= '0;
            r_lsel[s] <= '0;
         end
      end else begin
         if (bus.in_valid_i && !w_all_ready && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (flush_i) begin
            r_out_valid <= 1'b0;
            r_state     <= RUN;
            r_done      <= '0;
         end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_op        <= w_op_next;
            r_sel       <= w_sel_next;
            r_done      <= '0;
            r_state     <= RUN;
         end else begin
            if (bus.out_ready_i) r_out_valid <= 1'b0;
            if (w_latch) begin
               r_state <= HOLD;
               for (int s = 0; s < int'(NUM_SRC); s++) begin
                  if (!r_done[s] && w_res_rdy[s]) begin
                     r_done[s] <= 1'b1;
                     r_val[s]  <= w_res_val[s];
                     r_lsel[s] <= w_res_sel[s];
                  end
               end
            end
         end
      end
   end

   assign bus.out_valid_o = r_out_valid;
   assign bus.op_data_o   = r_op;
   assign bus.fwd_sel_o   = r_sel;
   assign stall_cnt_o     = r_cnt;
endmodule

// File: tb/tb_fwd_operand_stage.sv
// Directed bench for fwd_operand_stage with a scoreboard of expected output bundles.
module tb_fwd_operand_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [1:0]  fwd_valid, fwd_pend;
   logic [9:0]  fwd_rd;
   logic [63:0] fwd_data;
   logic [1:0]  stall_cnt;

   typedef struct packed {
      logic [63:0] op;
      logic [3:0]  sel;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   exp_cnt = 0;

   fwd_operand_stage_if #(.XLEN(32), .NUM_SRC(2), .AW(5), .SEL_W(2)) bus ();

   fwd_operand_stage #(
      .XLEN    (32),
      .NUM_SRC (2),
      .NUM_FWD (2),
      .AW      (5),
      .CNT_W   (2)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .bus         (bus),
      .fwd_valid_i (fwd_valid),
      .fwd_pend_i  (fwd_pend),
      .fwd_rd_i    (fwd_rd),
      .fwd_data_i  (fwd_data),
      .stall_cnt_o (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [63:0] op, input logic [3:0] sel);
      exp_t e;
      e.op  = op;
      e.sel = sel;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input string tag);
      exp_t e;
      chk({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_valid"}, 64'(bus.out_valid_o), 64'd1);
         chk({tag, "_op"}, bus.op_data_o, e.op);
         chk({tag, "_sel"}, 64'(bus.fwd_sel_o), 64'(e.sel));
      end
   endtask

   task automatic drive(input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [31:0] rf0, input logic [31:0] rf1);
      bus.rs_addr_i  = {rs1, rs0};
      bus.rf_data_i  = {rf1, rf0};
      bus.in_valid_i = 1'b1;
   endtask

   task automatic fwd(input logic [1:0] v, input logic [1:0] p, input logic [4:0] rd0,
                      input logic [4:0] rd1, input logic [31:0] d0, input logic [31:0] d1);
      fwd_valid = v;
      fwd_pend  = p;
      fwd_rd    = {rd1, rd0};
      fwd_data  = {d1, d0};
   endtask

   task automatic hazard_cycle();
      if (exp_cnt < 3) exp_cnt++;
   endtask

   initial begin
      rst = 1'b0;
      flush = 1'b0;
      bus.in_valid_i = 1'b0;
      bus.out_ready_i = 1'b1;
      bus.rs_addr_i = '0;
      bus.rf_data_i = '0;
      fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      tick();
      tick();
      chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
      chk("rst_op", bus.op_data_o, 64'd0);
      chk("rst_sel", 64'(bus.fwd_sel_o), 64'd0);
      chk("rst_cnt", 64'(stall_cnt), 64'd0);
      rst = 1'b1;
      tick();

      // No hazard
      drive(5'd1, 5'd2, 32'hA, 32'hB);
      #1;
      chk("t1_in_ready", 64'(bus.in_ready_o), 64'd1);
      push({32'hB, 32'hA}, 4'b0000);
      tick();
      bus.in_valid_i = 1'b0;
      pop_chk("t1");

      // Youngest level wins, then x0, then a shared register
      fwd(2'b11, 2'b00, 5'd3, 5'd3, 32'h11, 32'h22);
      drive(5'd3, 5'd1, 32'hA, 32'hB);
      #1;
      chk("t2a_in_ready", 64'(bus.in_ready_o), 64'd1);
      push({32'hB, 32'h11}, 4'b0001);
      tick();
      pop_chk("t2a");
      drive(5'd0, 5'd1, 32'hA, 32'hB);
      #1;
      chk("t2b_in_ready", 64'(bus.in_ready_o), 64'd1);
      push({32'hB, 32'h0}, 4'b0000);
      tick();
      pop_chk("t2b");
      fwd(2'b10, 2'b00, 5'd3, 5'd3, 32'h11, 32'h22);
      drive(5'd3, 5'd3, 32'hA, 32'hB);
      #1;
      push({32'h22, 32'h22}, 4'b1010);
      tick();
      bus.in_valid_i = 1'b0;
      pop_chk("t2c");

      // Load-use: src1 latches early and must not be overwritten
      rst = 1'b0;
      tick();
      rst = 1'b1;
      exp_cnt = 0;
      fwd(2'b11, 2'b01, 5'd5, 5'd6, 32'hDEAD, 32'h77);
      drive(5'd5, 5'd6, 32'hA, 32'hB);
      #1;
      chk("t3_stall_ready", 64'(bus.in_ready_o), 64'd0);
      hazard_cycle();
      tick();
      fwd(2'b10, 2'b00, 5'd0, 5'd5, 32'h0, 32'h55);
      #1;
      chk("t3_resolved_ready", 64'(bus.in_ready_o), 64'd1);
      chk("t3_cnt_hold", 64'(stall_cnt), 64'(exp_cnt));
      push({32'h77, 32'h55}, 4'b1010);
      tick();
      bus.in_valid_i = 1'b0;
      fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      pop_chk("t3");
      chk("t3_cnt", 64'(stall_cnt), 64'(exp_cnt));
      tick();

      // Backpressure with a second bundle waiting
      bus.out_ready_i = 1'b0;
      drive(5'd1, 5'd2, 32'hA, 32'hB);
      #1;
      chk("t4a_in_ready", 64'(bus.in_ready_o), 64'd1);
      push({32'hB, 32'hA}, 4'b0000);
      tick();
      drive(5'd1, 5'd2, 32'hC, 32'hD);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4_bp_ready", 64'(bus.in_ready_o), 64'd0);
         chk("t4_bp_op", bus.op_data_o, {32'hB, 32'hA});
         chk("t4_bp_cnt", 64'(stall_cnt), 64'(exp_cnt));
         tick();
      end
      bus.out_ready_i = 1'b1;
      #1;
      chk("t4b_in_ready", 64'(bus.in_ready_o), 64'd1);
      pop_chk("t4a");
      push({32'hD, 32'hC}, 4'b0000);
      tick();
      bus.in_valid_i = 1'b0;
      pop_chk("t4b");
      tick();

      // Flush in HOLD beats a simultaneous load; the next bundle starts clean
      fwd(2'b01, 2'b01, 5'd5, 5'd0, 32'h99, 32'h0);
      drive(5'd5, 5'd1, 32'hA, 32'hB);
      hazard_cycle();
      tick();
      fwd(2'b01, 2'b00, 5'd5, 5'd0, 32'h99, 32'h0);
      flush = 1'b1;
      #1;
      chk("t5_flush_ready", 64'(bus.in_ready_o), 64'd0);
      tick();
      flush = 1'b0;
      bus.in_valid_i = 1'b0;
      chk("t5_flush_valid", 64'(bus.out_valid_o), 64'd0);
      tick();
      drive(5'd5, 5'd1, 32'hF, 32'hE);
      #1;
      chk("t5_in_ready", 64'(bus.in_ready_o), 64'd1);
      push({32'hE, 32'h99}, 4'b0001);
      tick();
      bus.in_valid_i = 1'b0;
      pop_chk("t5");
      tick();

      // Counter saturation, then reset mid-HOLD
      fwd(2'b01, 2'b01, 5'd5, 5'd0, 32'h33, 32'h0);
      drive(5'd5, 5'd1, 32'hA, 32'hB);
      for (int i = 0; i < 5; i++) begin
         hazard_cycle();
         tick();
         chk("t6_cnt", 64'(stall_cnt), 64'(exp_cnt));
      end
      rst = 1'b0;
      tick();
      exp_cnt = 0;
      chk("t6_rst_valid", 64'(bus.out_valid_o), 64'd0);
      chk("t6_rst_op", bus.op_data_o, 64'd0);
      chk("t6_rst_sel", 64'(bus.fwd_sel_o), 64'd0);
      chk("t6_rst_cnt", 64'(stall_cnt), 64'd0);
      rst = 1'b1;
      fwd(2'b01, 2'b00, 5'd5, 5'd0, 32'h33, 32'h0);
      #1;
      chk("t6_in_ready", 64'(bus.in_ready_o), 64'd1);
      push({32'hB, 32'h33}, 4'b0001);
      tick();
      bus.in_valid_i = 1'b0;
      pop_chk("t6");
      tick();

      // Pending level leaves the bus: fall back to the register file
      fwd(2'b01, 2'b01, 5'd7, 5'd0, 32'h44, 32'h0);
      drive(5'd7, 5'd2, 32'h1111, 32'h2222);
      hazard_cycle();
      tick();
      fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      #1;
      chk("t7_in_ready", 64'(bus.in_ready_o), 64'd1);
      push({32'h2222, 32'h1111}, 4'b0000);
      tick();
      bus.in_valid_i = 1'b0;
      pop_chk("t7");
      chk("t7_cnt", 64'(stall_cnt), 64'(exp_cnt));
      chk("t7_sb_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
